pci_defsm_addr_decode: RTL

- Address-phase decoder and transaction dispatcher, directly upstream of the configuration-space manager and the memory target FSM.
- Detects the PCI address phase and latches address and command.
- Claims type-0 configuration cycles (IDSEL) and memory cycles that hit BAR0 or BAR1, then hands the transaction to the selected target FSM.
- Holds address and direction stable until that FSM signals end, then waits for bus idle before re-arming.

---
 rtl/pci_defsm_addr_decode.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/pci_defsm_addr_decode.sv
// PCI address-phase decoder: latches address/command, claims type-0 config
// and BAR0/BAR1 memory cycles, dispatches to the target FSMs, re-arms at bus idle.
`timescale 1ns/1ps
module pci_defsm_addr_decode #(
  parameter int BAR_LSB = 20,
  parameter int TIMEOUT = 16
) (
  input  logic        PHY_CLK33_I,
  input  logic        PHY_RST_I,
  input  logic        PCI_FRAMEn_I,
  input  logic        PCI_IRDYn_I,
  input  logic        PCI_IDSEL_I,
  input  logic [31:0] PCI_AD_I,
  input  logic [3:0]  PCI_CBEn_I,
  input  logic [31:0] CFG_REG_0x04_I,
  input  logic [31:0] CFG_REG_0x10_I,
  input  logic [31:0] CFG_REG_0x11_I,
  input  logic        DEFSM_CFG_END_I,
  input  logic        DEFSM_MEM_END_I,
  output logic        DEFSM_ADD2CFG_O,
  output logic        DEFSM_ADD2MEM_O,
  output logic        DEFSM_BAR_SEL_O,
  output logic        CFG_WR_O,
  output logic [21:0] PCI_ADD_O,
  output logic [3:0]  PCI_CMD_O,
  output logic        DEFSM_BUSY_O,
  output logic        DEFSM_TIMEOUT_O
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CFG_BUSY  = 2'd1,
    MEM_BUSY  = 2'd2,
    WAIT_IDLE = 2'd3
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        framen_d_q;
  logic        post_rst_q;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic        add2cfg_q, add2cfg_d;
  logic        add2mem_q, add2mem_d;
  logic        bar_sel_q, bar_sel_d;
  logic        cfg_wr_q, cfg_wr_d;
  logic [21:0] pci_add_q, pci_add_d;
  logic [3:0]  pci_cmd_q, pci_cmd_d;
  logic        busy_q, busy_d;
  logic        timeout_q, timeout_d;

  logic [3:0]  cmd_s;
  logic        cfg_cmd_s, mem_cmd_s;
  logic        bar0_hit_s, bar1_hit_s;
  logic        cfg_claim_s, mem_claim_s;
  logic        addr_phase_s, end_s;
  logic        unused_bits_s;

  assign unused_bits_s = ^{CFG_REG_0x04_I[31:2], CFG_REG_0x04_I[0],
                           CFG_REG_0x10_I[BAR_LSB-1:0], CFG_REG_0x11_I[BAR_LSB-1:0]};

  always_comb begin
    cmd_s     = ~PCI_CBEn_I;
    cfg_cmd_s = 1'b0;
    mem_cmd_s = 1'b0;
    case (cmd_s)
      4'hA, 4'hB:                   cfg_cmd_s = 1'b1;
      4'h6, 4'h7, 4'hC, 4'hE, 4'hF: mem_cmd_s = 1'b1;
      default: begin
        cfg_cmd_s = 1'b0;
        mem_cmd_s = 1'b0;
      end
    endcase
    // An unprogrammed (all-zero) BAR must never claim a cycle.
    bar0_hit_s = (PCI_AD_I[31:BAR_LSB] == CFG_REG_0x10_I[31:BAR_LSB]) &&
                 (|CFG_REG_0x10_I[31:BAR_LSB]);
    bar1_hit_s = (PCI_AD_I[31:BAR_LSB] == CFG_REG_0x11_I[31:BAR_LSB]) &&
                 (|CFG_REG_0x11_I[31:BAR_LSB]);
    cfg_claim_s = cfg_cmd_s && PCI_IDSEL_I && (PCI_AD_I[1:0] == 2'b00);
    mem_claim_s = mem_cmd_s && CFG_REG_0x04_I[1] && (bar0_hit_s || bar1_hit_s);
    // The cycle right after reset is blocked so a FRAME# held low across reset is not taken as a new address phase.
    addr_phase_s = (state_q == IDLE) && framen_d_q && !PCI_FRAMEn_I && !post_rst_q;
    end_s = (state_q == CFG_BUSY) ? DEFSM_CFG_END_I : DEFSM_MEM_END_I;
  end

  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    add2cfg_d = 1'b0;
    add2mem_d = 1'b0;
    timeout_d = 1'b0;
    busy_d    = busy_q;
    bar_sel_d = bar_sel_q;
    cfg_wr_d  = cfg_wr_q;
    pci_add_d = pci_add_q;
    pci_cmd_d = pci_cmd_q;
    case (state_q)
      IDLE: begin
        if (addr_phase_s) begin
          pci_add_d = PCI_AD_I[23:2];
          pci_cmd_d = cmd_s;
          cfg_wr_d  = cmd_s[0];
          bar_sel_d = !bar0_hit_s && bar1_hit_s;
          tmo_cnt_d = 8'd0;
          if (cfg_claim_s) begin
            state_d   = CFG_BUSY;
            add2cfg_d = 1'b1;
            busy_d    = 1'b1;
          end else if (mem_claim_s) begin
            state_d   = MEM_BUSY;
            add2mem_d = 1'b1;
            busy_d    = 1'b1;
          end else begin
            state_d   = WAIT_IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CFG_BUSY, MEM_BUSY: begin
        // END has priority over a timeout landing in the same cycle.
        if (end_s) begin
          state_d = WAIT_IDLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = WAIT_IDLE;
          timeout_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      WAIT_IDLE: begin
        if (PCI_FRAMEn_I && PCI_IRDYn_I) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = WAIT_IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PHY_CLK33_I) begin
    if (PHY_RST_I) begin
      state_q    <= IDLE;
      framen_d_q <= 1'b1;
      post_rst_q <= 1'b1;
      tmo_cnt_q  <= 8'd0;
      add2cfg_q  <= 1'b0;
      add2mem_q  <= 1'b0;
      bar_sel_q  <= 1'b0;
      cfg_wr_q   <= 1'b0;
      pci_add_q  <= 22'd0;
      pci_cmd_q  <= 4'd0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      framen_d_q <= PCI_FRAMEn_I;
      post_rst_q <= 1'b0;
      tmo_cnt_q  <= tmo_cnt_d;
      add2cfg_q  <= add2cfg_d;
      add2mem_q  <= add2mem_d;
      bar_sel_q  <= bar_sel_d;
      cfg_wr_q   <= cfg_wr_d;
      pci_add_q  <= pci_add_d;
      pci_cmd_q  <= pci_cmd_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign DEFSM_ADD2CFG_O = add2cfg_q;
  assign DEFSM_ADD2MEM_O = add2mem_q;
  assign DEFSM_BAR_SEL_O = bar_sel_q;
  assign CFG_WR_O        = cfg_wr_q;
  assign PCI_ADD_O       = pci_add_q;
  assign PCI_CMD_O       = pci_cmd_q;
  assign DEFSM_BUSY_O    = busy_q;
  assign DEFSM_TIMEOUT_O = timeout_q;

endmodule
